tiled_temporal_mxu: RTL
=======================

TILED_TEMPORAL_MXU -- requirements
Module: tiled_temporal_mxu

Interface
REQ-001 SHALL have parameter DIM, default 4, matrix dimension (square DIM x DIM).
REQ-002 SHALL have parameter BIT_WIDTH, default 4, operand element width.
REQ-003 SHALL have parameter LANES, default 2, parallel row engines; DIM % LANES == 0, LANES >= 1, else elaboration error.
REQ-004 SHALL have parameter OUT_WIDTH, default 2*BIT_WIDTH+$clog2(DIM), result element width.
REQ-005 SHALL have port clk, input, 1, single clock; all state on posedge clk.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, job request.
REQ-008 SHALL have port in_ready, output, 1, job can be accepted.
REQ-009 SHALL have port A, input, [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0], A[r][k] = row r, column k.
REQ-010 SHALL have port B, input, [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0], B[k][c] = row k, column c.
REQ-011 SHALL have port signed_mode, input, 1, 1 = A and B two's complement, 0 = unsigned.
REQ-012 SHALL have port accumulate, input, 1, 1 = add result onto current C.
REQ-013 SHALL have port abort, input, 1, cancel job in progress.
REQ-014 SHALL have port out_valid, output, 1, C holds a completed result.
REQ-015 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-016 SHALL have port C, output, [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0], result matrix, registered.
REQ-017 SHALL have port busy, output, 1, high when state is COMP.

Function
REQ-018 SHALL use states IDLE, COMP, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-019 SHALL, in IDLE, accept a job on in_valid && in_ready: register A, B, signed_mode and accumulate, and enter COMP; these inputs are ignored outside the accepting edge.
REQ-020 SHALL compute C[r][c] = sum over k of A[r][k]*B[k][c], plus the old C[r][c] when accumulate = 1, modulo 2^OUT_WIDTH (two's-complement wrap, no saturation).
REQ-021 SHALL encode each A element temporally: window W = 2^BIT_WIDTH - 1 cycles, counter t = 0..W-1; in step t, for every k with t < |A[r][k]|, add B[k][c] (sign-extended when signed_mode) to the lane accumulator, or subtract it if A[r][k] < 0.
REQ-022 SHALL schedule P = DIM/LANES passes; in pass p, lane l handles row p*LANES+l; columns c = 0..DIM-1 in order, one window each.
REQ-023 SHALL seed each lane accumulator at window start with old C[r][c] when accumulate = 1, else 0, and write C[r][c] on the t = W-1 edge.
REQ-024 SHALL leave COMP for DONE on the edge exactly P*DIM*W cycles after the accepting edge; C elements not yet written keep their old values during COMP and are not guaranteed consistent until out_valid.
REQ-025 SHALL hold DONE with C stable until out_valid && out_ready, then enter IDLE on that edge; C retains its value in IDLE.
REQ-026 SHALL, on abort = 1 in COMP, go to IDLE on the next edge; C contents are then unspecified; out_valid does not assert for that job. abort is ignored in IDLE and DONE.
REQ-027 SHALL give abort priority over the final COMP-to-DONE transition when both occur on the same edge.
REQ-028 SHALL handle the most negative signed A (magnitude 2^(BIT_WIDTH-1) <= W) correctly.

Reset
REQ-029 SHALL, while reset_n = 0, force state IDLE, all of C to 0, window and column counters to 0, and pass counter to 0, regardless of clk.
REQ-030 SHALL give in_ready = 1, out_valid = 0 and busy = 0 after reset, including reset applied during COMP or DONE.

Verification (DIM=4, BIT_WIDTH=4, LANES=2, OUT_WIDTH=10, so W=15 and latency=120)
REQ-031 SHALL cover: unsigned, A = identity, B[k][c] = 4k+c -> C == B, out_valid rises exactly 120 cycles after the accepting edge, busy high for those 120 cycles.
REQ-032 SHALL cover: unsigned, all A = 15, all B = 15 -> every C = 900.
REQ-033 SHALL cover: signed, all A = 4'h8 (-8), all B = 7 -> every C = 10'h320 (-224).
REQ-034 SHALL cover: REQ-032 job, then the same job with accumulate = 1 -> every C = 776 (1800 mod 1024).
REQ-035 SHALL cover: out_ready held low 10 cycles in DONE -> out_valid stays 1, C stable, in_ready 0, in_valid pulses ignored; IDLE on the first cycle with out_ready = 1.
REQ-036 SHALL cover: abort at cycle 30 of COMP -> IDLE and in_ready = 1 next edge, out_valid never 1; then reset_n low mid-COMP -> C all 0, in_ready = 1 immediately.

Source files
------------

// File: rtl/tiled_temporal_mxu.sv
// Integer matrix multiply C = A*B (+C), LANES row engines, A elements applied as pulse-count windows.
// Latency: exactly (DIM/LANES)*DIM*(2^BIT_WIDTH-1) cycles from the accepting edge to out_valid.
// Backpressure: one job at a time; in_ready only in IDLE, result held in DONE until out_ready.
module tiled_temporal_mxu #(
    parameter int DIM       = 4,
    parameter int BIT_WIDTH = 4,
    parameter int LANES     = 2,
    parameter int OUT_WIDTH = 2*BIT_WIDTH + $clog2(DIM)
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]        A,
    input  logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]        B,
    input  logic                                          signed_mode,
    input  logic                                          accumulate,
    input  logic                                          abort,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0]        C,
    output logic                                          busy
);

    // Window length, pass count and counter widths.
    localparam int W  = (1 << BIT_WIDTH) - 1;
    localparam int P  = DIM / LANES;
    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    localparam logic [BIT_WIDTH-1:0] T_LAST = BIT_WIDTH'(W - 1);
    localparam logic [IW-1:0]        C_LAST = IW'(DIM - 1);
    localparam logic [PW-1:0]        P_LAST = PW'(P - 1);

    // Reject configurations where lanes cannot tile the rows evenly.
    generate
        if ((LANES < 1) || (DIM % LANES != 0)) begin : g_bad_cfg
            $error("tiled_temporal_mxu: LANES must be >= 1 and divide DIM");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                                   state_q;
    logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]   a_q;
    logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]   b_q;
    logic                                     sgn_q;
    logic                                     accm_q;
    logic [BIT_WIDTH-1:0]                     t_q;
    logic [IW-1:0]                            col_q;
    logic [PW-1:0]                            pass_q;
    logic [LANES-1:0][OUT_WIDTH-1:0]          lane_acc_q;
    logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0]   c_q;

    logic [LANES-1:0][IW-1:0]                 row_idx;
    logic [LANES-1:0][OUT_WIDTH-1:0]          lane_sum_d;

    // Contribution of one A element during step t: +B, -B or nothing.
    // Magnitude of the most negative value (e.g. -8 -> 4'b1000) still fits BIT_WIDTH bits.
    function automatic logic [OUT_WIDTH-1:0] step_term(
        input logic [BIT_WIDTH-1:0] a_el,
        input logic [BIT_WIDTH-1:0] b_el,
        input logic                 sgn,
        input logic [BIT_WIDTH-1:0] t
    );
        logic                 neg;
        logic [BIT_WIDTH-1:0] mag;
        logic [OUT_WIDTH-1:0] b_ext;
        neg   = sgn & a_el[BIT_WIDTH-1];
        mag   = neg ? (~a_el + 1'b1) : a_el;
        b_ext = sgn ? {{(OUT_WIDTH-BIT_WIDTH){b_el[BIT_WIDTH-1]}}, b_el}
                    : {{(OUT_WIDTH-BIT_WIDTH){1'b0}}, b_el};
        if (t < mag) begin
            step_term = neg ? (~b_ext + 1'b1) : b_ext;
        end else begin
            step_term = '0;
        end
    endfunction

    // Per-lane row selection and next accumulator value (seeded at window start).
    always_comb begin
        row_idx    = '0;
        lane_sum_d = '0;
        for (int l = 0; l < LANES; l++) begin
            row_idx[l] = IW'(int'(pass_q) * LANES + l);
            if (t_q == '0) begin
                lane_sum_d[l] = accm_q ? c_q[row_idx[l]][col_q] : '0;
            end else begin
                lane_sum_d[l] = lane_acc_q[l];
            end
            for (int k = 0; k < DIM; k++) begin
                lane_sum_d[l] = lane_sum_d[l]
                              + step_term(a_q[row_idx[l]][k], b_q[k][col_q], sgn_q, t_q);
            end
        end
    end

    // Control FSM, schedule counters, operand capture and result write-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            accm_q     <= 1'b0;
            t_q        <= '0;
            col_q      <= '0;
            pass_q     <= '0;
            lane_acc_q <= '0;
            c_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        sgn_q   <= signed_mode;
                        accm_q  <= accumulate;
                        t_q     <= '0;
                        col_q   <= '0;
                        pass_q  <= '0;
                        state_q <= COMP;
                    end
                end
                COMP: begin
                    if (abort) begin
                        // Abort wins over a simultaneous completion.
                        t_q     <= '0;
                        col_q   <= '0;
                        pass_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        lane_acc_q <= lane_sum_d;
                        if (t_q == T_LAST) begin
                            for (int l = 0; l < LANES; l++) begin
                                c_q[row_idx[l]][col_q] <= lane_sum_d[l];
                            end
                            t_q <= '0;
                            if (col_q == C_LAST) begin
                                col_q <= '0;
                                if (pass_q == P_LAST) begin
                                    pass_q  <= '0;
                                    state_q <= DONE;
                                end else begin
                                    pass_q <= pass_q + 1'b1;
                                end
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end else begin
                            t_q <= t_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == COMP);
    assign C         = c_q;

endmodule
